// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Output word layout is {pc[17:2], inst[31:0]}.
package fetch_pkg;

    localparam int unsigned INST_W   = 32;
    localparam int unsigned F_INST_W = 48;
    localparam int unsigned F_PC_HI  = 47;
    localparam int unsigned F_PC_LO  = 32;

    typedef struct packed {
        logic [31:0]       pc;
        logic              mode;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        mode;
    } fetch_tag_t;

    typedef enum logic [0:0] {
        StBoot,
        StRun
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry shift FIFO with flush; slot0 is always the head.
// The head register keeps its contents when the FIFO drains or is flushed.
module fetch_fifo #(
    parameter type T = logic
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push_i,
    input  T           data_i,
    input  logic       pop_i,
    input  logic       flush_i,
    output logic [1:0] count_o,
    output T           head_o
);
    T           slot0_q, slot0_d;
    T           slot1_q, slot1_d;
    logic [1:0] count_q, count_d;
    logic       do_push, do_pop;

    always_comb begin
        do_pop  = pop_i && (count_q != 2'd0);
        do_push = push_i && ((count_q != 2'd2) || do_pop);
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count_q == 2'd0) slot0_d = data_i;
                    else                 slot1_d = data_i;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd2) slot0_d = slot1_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        slot0_d = data_i;
                    end else begin
                        slot0_d = slot1_q;
                        slot1_d = data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = slot0_q;

endmodule

// File: rtl/pipeline_f.sv
// MIPS instruction-fetch stage: issues word fetches on a valid/grant channel, buffers up
// to two returned words for the T stage and discards wrong-path responses after a redirect.
module pipeline_f
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
    parameter logic        RESET_MODE = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req,
    output logic [31:0]         imem_addr,
    input  logic                imem_gnt,
    input  logic                imem_rvalid,
    input  logic [INST_W-1:0]   imem_rdata,
    input  logic                t_stall,
    input  logic                redirect,
    input  logic [31:0]         redirect_pc,
    input  logic                redirect_mode,
    output logic [F_INST_W-1:0] f_inst,
    output logic                f_mode,
    output logic                f_bubble
);
    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         mode_q, mode_d;
    logic [1:0]   drop_q, drop_d;
    logic [1:0]   tag_count, out_count;
    logic [2:0]   credits_used;
    fetch_tag_t   tag_head;
    fetch_entry_t out_head, out_entry;
    logic         grant, rsp_ok, rsp_keep, head_valid, pop;
    logic         unused_ok;

    // The tag queue occupancy is the count of granted-but-unanswered requests.
    assign head_valid   = (out_count != 2'd0);
    assign pop          = head_valid && !t_stall && !redirect;
    assign grant        = imem_req && imem_gnt;
    assign rsp_ok       = imem_rvalid && (tag_count != 2'd0);
    assign rsp_keep     = rsp_ok && (drop_q == 2'd0) && !redirect;
    assign credits_used = {1'b0, tag_count} + {1'b0, out_count};
    assign out_entry    = {tag_head.pc, tag_head.mode, imem_rdata};

    always_ff @(posedge clk) begin
        if (reset) state_q <= StBoot;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StBoot:  state_d = StRun;
            StRun:   state_d = StRun;
            default: state_d = StBoot;
        endcase
    end

    always_comb begin
        imem_req = 1'b0;
        if ((state_q == StRun) && !redirect) begin
            imem_req = (credits_used < 3'd2) || pop;
        end
    end

    always_comb begin
        pc_d   = pc_q;
        mode_d = mode_q;
        drop_d = drop_q;
        if (redirect) begin
            pc_d   = {redirect_pc[31:2], 2'b00};
            mode_d = redirect_mode;
            // A response landing this cycle is already accounted as discarded.
            drop_d = tag_count - {1'b0, rsp_ok};
        end else begin
            if (grant) pc_d = pc_q + 32'd4;
            if (rsp_ok && (drop_q != 2'd0)) drop_d = drop_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q   <= RESET_PC;
            mode_q <= RESET_MODE;
            drop_q <= 2'd0;
        end else begin
            pc_q   <= pc_d;
            mode_q <= mode_d;
            drop_q <= drop_d;
        end
    end

    fetch_fifo #(
        .T(fetch_tag_t)
    ) u_tag_fifo (
        .clk    (clk),
        .reset  (reset),
        .push_i (grant),
        .data_i ({pc_q, mode_q}),
        .pop_i  (rsp_ok),
        .flush_i(1'b0),
        .count_o(tag_count),
        .head_o (tag_head)
    );

    fetch_fifo #(
        .T(fetch_entry_t)
    ) u_out_fifo (
        .clk    (clk),
        .reset  (reset),
        .push_i (rsp_keep),
        .data_i (out_entry),
        .pop_i  (pop),
        .flush_i(redirect),
        .count_o(out_count),
        .head_o (out_head)
    );

    assign imem_addr = pc_q;
    assign f_inst    = {out_head.pc[17:2], out_head.inst};
    assign f_mode    = out_head.mode;
    assign f_bubble  = !head_valid || redirect;

    assign unused_ok = ^{redirect_pc[1:0], out_head.pc[31:18], out_head.pc[1:0]};

endmodule
